// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing BRAM port B between the LSU and
//               the loader/debug DMA; one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [1:0]  m0_op,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [1:0]  m1_op,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [1:0]  mem_op,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] c_stIdle  = 2'd0;
    localparam logic [1:0] c_stIssue = 2'd1;
    localparam logic [1:0] c_stWait  = 2'd2;
    localparam logic [1:0] c_stResp  = 2'd3;
    localparam logic [1:0] c_opStore = 2'b11;
    localparam logic [2:0] c_rdLat   = 3'(RD_LAT);

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic       r_owner;
    logic       r_rrPrio;
    logic [2:0] r_count;
    logic       w_m0Valid;
    logic       w_m1Valid;
    logic       w_select;
    logic       w_selOwner;

    assign w_m0Valid = m0_req && (m0_op != 2'b00);
    assign w_m1Valid = m1_req && (m1_op != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_select    = 1'b0;
        w_selOwner  = 1'b0;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        busy        = (r_state != c_stIdle);
        case (r_state)
            c_stIdle: begin
                if (w_m0Valid || w_m1Valid) begin
                    w_select    = 1'b1;
                    w_selOwner  = (w_m0Valid && w_m1Valid) ? r_rrPrio : w_m1Valid;
                    w_nextState = c_stIssue;
                end
            end
            c_stIssue: begin
                m0_gnt      = ~r_owner;
                m1_gnt      = r_owner;
                w_nextState = (mem_op == c_opStore) ? c_stIdle : c_stWait;
            end
            c_stWait: begin
                if (r_count == 3'd1) begin
                    w_nextState = c_stResp;
                end
            end
            c_stResp: begin
                m0_rvalid   = ~r_owner;
                m1_rvalid   = r_owner;
                w_nextState = c_stIdle;
            end
            default: w_nextState = c_stIdle;
        endcase
    end

    // mem_op is only non-zero during the ISSUE cycle; the other fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_op    <= 2'b00;
            mem_size  <= 2'b00;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            r_owner   <= 1'b0;
            r_rrPrio  <= 1'b0;
            r_count   <= 3'd0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            mem_op <= 2'b00;
            if (w_select) begin
                r_owner <= w_selOwner;
                if (w_selOwner) begin
                    mem_op    <= m1_op;
                    mem_size  <= m1_size;
                    mem_addr  <= m1_addr;
                    mem_wdata <= m1_wdata;
                end else begin
                    mem_op    <= m0_op;
                    mem_size  <= m0_size;
                    mem_addr  <= m0_addr;
                    mem_wdata <= m0_wdata;
                end
            end
            if (r_state == c_stIssue) begin
                r_rrPrio <= ~r_owner;
                r_count  <= c_rdLat;
            end
            if (r_state == c_stWait) begin
                r_count <= r_count - 3'd1;
                if (r_count == 3'd1) begin
                    if (r_owner) begin
                        m1_rdata <= mem_rdata;
                    end else begin
                        m0_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
